module_data_arbiter: RTL and testbench

Round-robin arbiter sharing the single singles-data path to the GigEx TX FIFO among the per-module RX data FIFOs. It replaces fixed-priority selection, so a busy module cannot starve the others. Each grant is held for a bounded burst. The output is registered as a valid/ready stage and carries the source module index. It sits in the `clk_100` domain, between the per-module FWFT RX data FIFOs and the Ethernet TX FIFO write port.

---
 rtl/backend_pkg.sv | 17 +
 rtl/module_data_arbiter_rr_pick.sv | 32 +++
 rtl/module_data_arbiter.sv | 123 ++++++++++++
 tb/tb_module_data_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backend_pkg.sv
// rtl/backend_pkg.sv - shared backend constants and arbiter state type
//
// Purpose : default module count / word width and the arbiter FSM state
//           encoding shared by the backend data path.
// Ports   : none (package).
package backend_pkg;

   localparam int NMODULES  = 4;
   localparam int LENGTH    = 128;
   localparam int MOD_IDX_W = $clog2(NMODULES);

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/module_data_arbiter_rr_pick.sv
// rtl/module_data_arbiter_rr_pick.sv - combinational rotating-priority picker
//
// Purpose : returns the first asserted request at or after index base,
//           wrapping modulo N.
// Ports   : req  [N]  request vector
//           base [W]  starting index (must be < N)
//           idx  [W]  selected index (0 when nothing requested)
//           any       at least one request is asserted
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] base,
   output logic [W-1:0] idx,
   output logic         any
);

   // Walk from the farthest offset back to offset 0 so the nearest
   // request (smallest offset from base) is the last one written.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(base) + i) % N]) begin
            idx = W'((int'(base) + i) % N);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/module_data_arbiter.sv
// rtl/module_data_arbiter.sv - round-robin burst arbiter from module RX FIFOs to TX FIFO
//
// Purpose : shares one registered valid/ready output among NMODULES FWFT
//           RX data FIFOs. Each grant lasts at most MAX_BURST accepted words;
//           one IDLE arbitration cycle separates grants.
// Ports   : clk, rst_n          clock, asynchronous active-low reset
//           m_en     [N]        per-module enable
//           in_data  [L*N]      module k word at [k*L +: L]
//           in_valid [N]        per-module FIFO not-empty
//           in_ready [N]        per-module FWFT pop (at most one bit high)
//           out_data [L]        registered output word
//           out_src  [IDX]      source module of out_data
//           out_valid/out_ready output handshake
//           stats_clr, word_count[32*N]  only with MODULE_ARB_STATS_EN
module module_data_arbiter #(
   parameter int NMODULES  = backend_pkg::NMODULES,
   parameter int LENGTH    = backend_pkg::LENGTH,
   parameter int MAX_BURST = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NMODULES-1:0]          m_en,
   input  logic [LENGTH*NMODULES-1:0]   in_data,
   input  logic [NMODULES-1:0]          in_valid,
   output logic [NMODULES-1:0]          in_ready,
   output logic [LENGTH-1:0]            out_data,
   output logic [$clog2(NMODULES)-1:0]  out_src,
   output logic                         out_valid,
   input  logic                         out_ready
`ifdef MODULE_ARB_STATS_EN
  ,input  logic                         stats_clr,
   output logic [32*NMODULES-1:0]       word_count
`endif
);

   import backend_pkg::*;

   localparam int IDX_W   = $clog2(NMODULES);
   localparam int BURST_W = $clog2(MAX_BURST + 1);

   arb_state_e          state_q;
   logic [IDX_W-1:0]    g_q, rr_q, rr_d, pick_idx;
   logic [BURST_W-1:0]  burst_cnt_q;
   logic                pick_any, space, xfer, last_word, leave;
   logic [LENGTH-1:0]   sel_data;

   rr_pick #(.N(NMODULES), .W(IDX_W)) u_pick (
      .req  (in_valid & m_en),
      .base (rr_q),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // Output register can take a word if empty or being drained this cycle.
   assign space     = ~out_valid | out_ready;
   assign xfer      = (state_q == ARB_GRANT) & in_valid[g_q] & m_en[g_q] & space;
   assign sel_data  = in_data[g_q*LENGTH +: LENGTH];
   assign last_word = (burst_cnt_q == BURST_W'(MAX_BURST - 1));
   // Backpressure alone never ends a grant; only burst end, empty or disable.
   assign leave     = (xfer & last_word) | ~in_valid[g_q] | ~m_en[g_q];
   assign rr_d      = (g_q == IDX_W'(NMODULES - 1)) ? '0 : g_q + 1'b1;

   always_comb begin
      in_ready      = '0;
      in_ready[g_q] = xfer;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         g_q         <= '0;
         rr_q        <= '0;
         burst_cnt_q <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_src     <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_any) begin
                  g_q         <= pick_idx;
                  burst_cnt_q <= '0;
                  state_q     <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (xfer)
                  burst_cnt_q <= burst_cnt_q + 1'b1;
               if (leave) begin
                  state_q <= ARB_IDLE;
                  rr_q    <= rr_d;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase

         if (xfer) begin
            out_data  <= sel_data;
            out_src   <= g_q;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef MODULE_ARB_STATS_EN
   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_count <= '0;
      end else begin
         for (int k = 0; k < NMODULES; k++) begin
            if (stats_clr)
               word_count[k*32 +: 32] <= '0;
            else if (xfer && (g_q == IDX_W'(k)))
               word_count[k*32 +: 32] <= word_count[k*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_module_data_arbiter.sv
// tb/tb_module_data_arbiter.sv - self-checking bench for module_data_arbiter
module tb_module_data_arbiter;

   localparam int N  = 4;
   localparam int L  = 128;
   localparam int MB = 16;
   localparam int IW = 2;
   localparam int DEPTH = 64;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    m_en, in_valid, in_ready;
   logic [L*N-1:0]  in_data;
   logic [L-1:0]    out_data;
   logic [IW-1:0]   out_src;
   logic            out_valid, out_ready;
`ifdef MODULE_ARB_STATS_EN
   logic            stats_clr;
   logic [32*N-1:0] word_count;
`endif

   always #5 clk = ~clk;

   module_data_arbiter #(.NMODULES(N), .LENGTH(L), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m_en      (m_en),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MODULE_ARB_STATS_EN
     ,.stats_clr  (stats_clr),
      .word_count (word_count)
`endif
   );

   logic [L-1:0] mem [N][DEPTH];
   int           head [N];
   int           tail [N];
   logic [L-1:0] obs_data [$];
   int           obs_src  [$];
   int           obs_cyc  [$];
   logic [L-1:0] exp_data [$];
   int           exp_src  [$];
   int           cyc, multi_cnt, bad_cnt, rdy_pct;
   bit           bp_force;
   logic [N-1:0] s_ir;
   logic         s_ov;
   logic [L-1:0] s_od;
   int           n_cmp, n_bad;

   function automatic logic [L-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push_words(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         mem[k][tail[k]] = rand_word();
         tail[k]++;
      end
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         in_valid[k]        = head[k] < tail[k];
         in_data[k*L +: L]  = (head[k] < tail[k]) ? mem[k][head[k]] : '0;
      end
   endtask

   function automatic bit busy();
      for (int k = 0; k < N; k++)
         if (m_en[k] && head[k] < tail[k]) return 1'b1;
      return out_valid;
   endfunction

   // One clock: sample at negedge, pop FIFOs after posedge, re-drive inputs.
   task automatic step();
      @(negedge clk);
      cyc++;
      s_ir = in_ready;
      s_ov = out_valid;
      s_od = out_data;
      if ($countones(in_ready) > 1) multi_cnt++;
      for (int k = 0; k < N; k++)
         if (in_ready[k] && !(m_en[k] && head[k] < tail[k])) bad_cnt++;
      if (out_valid && out_ready) begin
         obs_data.push_back(out_data);
         obs_src.push_back(int'(out_src));
         obs_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
         if (s_ir[k]) head[k]++;
      drive();
      out_ready = bp_force ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
   endtask

   task automatic run_idle(input int budget, output bit timed_out);
      int n;
      n = 0;
      timed_out = 1'b0;
      while (busy()) begin
         if (n >= budget) begin
            timed_out = 1'b1;
            break;
         end
         step();
         n++;
      end
   endtask

   // Reference: round robin over non-empty enabled queues, bursts of at most MB.
   task automatic build_model();
      int mh [N];
      int rr, g, b;
      exp_data.delete();
      exp_src.delete();
      for (int k = 0; k < N; k++) mh[k] = head[k];
      rr = 0;
      forever begin
         g = -1;
         for (int i = 0; i < N; i++)
            if (g < 0 && m_en[(rr + i) % N] && mh[(rr + i) % N] < tail[(rr + i) % N])
               g = (rr + i) % N;
         if (g < 0) break;
         b = tail[g] - mh[g];
         if (b > MB) b = MB;
         for (int i = 0; i < b; i++) begin
            exp_data.push_back(mem[g][mh[g] + i]);
            exp_src.push_back(g);
         end
         mh[g] += b;
         rr = (g + 1) % N;
      end
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      bp_force  = 1'b0;
      rdy_pct   = 100;
      out_ready = 1'b1;
      m_en      = '1;
`ifdef MODULE_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      for (int k = 0; k < N; k++) begin
         head[k] = 0;
         tail[k] = 0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      obs_data.delete();
      obs_src.delete();
      obs_cyc.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) push_words(k, 1);
      drive();
      @(posedge clk);
      #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== '0)    begin n_bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
      n_cmp++; if (out_src !== '0)     begin n_bad++; $display("FAIL reset out_src: got %0d want 0", out_src); end
      n_cmp++; if (in_ready !== '0)    begin n_bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset idle_cycle in_ready: got %b want 0000", in_ready); end
      @(negedge clk);
      n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL reset first_grant in_ready: got %b want 0001", in_ready); end
   endtask

   task automatic test_single();
      bit to;
      apply_reset();
      push_words(2, 20);
      drive();
      build_model();
      run_idle(500, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL single timeout: got busy want idle"); end
      n_cmp++; if (obs_src.size() != exp_src.size()) begin n_bad++; $display("FAIL single count: got %0d want %0d", obs_src.size(), exp_src.size()); end
      for (int i = 0; i < obs_src.size() && i < exp_src.size(); i++) begin
         n_cmp++;
         if (obs_src[i] !== exp_src[i] || obs_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL single word %0d: got src %0d data %h want src %0d data %h", i, obs_src[i], obs_data[i], exp_src[i], exp_data[i]);
         end
      end
      if (obs_cyc.size() >= 17) begin
         n_cmp++; if (obs_cyc[15] - obs_cyc[0] != 15) begin n_bad++; $display("FAIL single burst_span: got %0d want 15", obs_cyc[15] - obs_cyc[0]); end
         n_cmp++; if (obs_cyc[16] - obs_cyc[15] != 2) begin n_bad++; $display("FAIL single bubble: got gap %0d want 2", obs_cyc[16] - obs_cyc[15]); end
      end
   endtask

   task automatic test_fairness();
      bit to;
      int run_len, max_run;
      apply_reset();
      for (int k = 0; k < N; k++) push_words(k, 40);
      drive();
      build_model();
      run_idle(1000, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL fair timeout: got busy want idle"); end
      n_cmp++; if (obs_src.size() != exp_src.size()) begin n_bad++; $display("FAIL fair count: got %0d want %0d", obs_src.size(), exp_src.size()); end
      for (int i = 0; i < obs_src.size() && i < exp_src.size(); i++) begin
         n_cmp++;
         if (obs_src[i] !== exp_src[i] || obs_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL fair word %0d: got src %0d data %h want src %0d data %h", i, obs_src[i], obs_data[i], exp_src[i], exp_data[i]);
         end
      end
      max_run = 0;
      run_len = 0;
      for (int i = 0; i < obs_src.size(); i++) begin
         run_len = (i > 0 && obs_src[i] == obs_src[i-1]) ? run_len + 1 : 1;
         if (run_len > max_run) max_run = run_len;
      end
      n_cmp++; if (max_run != MB) begin n_bad++; $display("FAIL fair max_run: got %0d want %0d", max_run, MB); end
   endtask

   task automatic test_backpressure();
      bit to;
      int n;
      logic [L-1:0] hold;
      apply_reset();
      push_words(0, 20);
      push_words(1, 5);
      drive();
      build_model();
      n = 0;
      while (obs_src.size() < 6 && n < 100) begin step(); n++; end
      bp_force  = 1'b1;
      out_ready = 1'b0;
      hold      = out_data;
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++; if (s_ov !== 1'b1) begin n_bad++; $display("FAIL bp out_valid cyc %0d: got %b want 1", i, s_ov); end
         n_cmp++; if (s_od !== hold) begin n_bad++; $display("FAIL bp out_data cyc %0d: got %h want %h", i, s_od, hold); end
         n_cmp++; if (s_ir !== '0)   begin n_bad++; $display("FAIL bp in_ready cyc %0d: got %b want 0", i, s_ir); end
      end
      bp_force  = 1'b0;
      out_ready = 1'b1;
      run_idle(500, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL bp timeout: got busy want idle"); end
      n_cmp++; if (obs_src.size() != exp_src.size()) begin n_bad++; $display("FAIL bp count: got %0d want %0d", obs_src.size(), exp_src.size()); end
      for (int i = 0; i < obs_src.size() && i < exp_src.size(); i++) begin
         n_cmp++;
         if (obs_src[i] !== exp_src[i] || obs_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL bp word %0d: got src %0d data %h want src %0d data %h", i, obs_src[i], obs_data[i], exp_src[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_enable_drop();
      bit dropped;
      int n, ir1_after;
      apply_reset();
      push_words(1, 10);
      push_words(2, 3);
      drive();
      exp_data.delete();
      exp_src.delete();
      for (int i = 0; i < 5; i++) begin exp_data.push_back(mem[1][i]); exp_src.push_back(1); end
      for (int i = 0; i < 3; i++) begin exp_data.push_back(mem[2][i]); exp_src.push_back(2); end
      dropped   = 1'b0;
      ir1_after = 0;
      n = 0;
      while (busy() && n < 500) begin
         step();
         n++;
         if (dropped && s_ir[1]) ir1_after++;
         if (!dropped && head[1] == 5) begin
            m_en[1] = 1'b0;
            dropped = 1'b1;
         end
      end
      n_cmp++; if (n >= 500) begin n_bad++; $display("FAIL endrop timeout: got busy want idle"); end
      n_cmp++; if (ir1_after != 0) begin n_bad++; $display("FAIL endrop in_ready1: got %0d pops want 0", ir1_after); end
      n_cmp++; if (obs_src.size() != exp_src.size()) begin n_bad++; $display("FAIL endrop count: got %0d want %0d", obs_src.size(), exp_src.size()); end
      for (int i = 0; i < obs_src.size() && i < exp_src.size(); i++) begin
         n_cmp++;
         if (obs_src[i] !== exp_src[i] || obs_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL endrop word %0d: got src %0d data %h want src %0d data %h", i, obs_src[i], obs_data[i], exp_src[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      bit to;
      int n;
      apply_reset();
      push_words(2, 20);
      drive();
      n = 0;
      while (obs_src.size() < 3 && n < 100) begin step(); n++; end
      push_words(0, 5);
      drive();
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== '0)    begin n_bad++; $display("FAIL areset out_data: got %h want 0", out_data); end
      n_cmp++; if (out_src !== '0)     begin n_bad++; $display("FAIL areset out_src: got %0d want 0", out_src); end
      n_cmp++; if (in_ready !== '0)    begin n_bad++; $display("FAIL areset in_ready: got %b want 0", in_ready); end
      #1;
      rst_n = 1'b1;
      obs_data.delete();
      obs_src.delete();
      obs_cyc.delete();
      build_model();
      run_idle(500, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL areset timeout: got busy want idle"); end
      n_cmp++; if (obs_src.size() != exp_src.size()) begin n_bad++; $display("FAIL areset count: got %0d want %0d", obs_src.size(), exp_src.size()); end
      for (int i = 0; i < obs_src.size() && i < exp_src.size(); i++) begin
         n_cmp++;
         if (obs_src[i] !== exp_src[i] || obs_data[i] !== exp_data[i]) begin
            n_bad++; $display("FAIL areset word %0d: got src %0d data %h want src %0d data %h", i, obs_src[i], obs_data[i], exp_src[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_random();
      bit to;
      for (int it = 0; it < 4; it++) begin
         apply_reset();
         m_en    = 4'($urandom_range(1, 15));
         rdy_pct = 60;
         for (int k = 0; k < N; k++) push_words(k, int'($urandom_range(0, 40)));
         drive();
         build_model();
         run_idle(4000, to);
         n_cmp++; if (to) begin n_bad++; $display("FAIL rand%0d timeout: got busy want idle", it); end
         n_cmp++; if (obs_src.size() != exp_src.size()) begin n_bad++; $display("FAIL rand%0d count: got %0d want %0d", it, obs_src.size(), exp_src.size()); end
         for (int i = 0; i < obs_src.size() && i < exp_src.size(); i++) begin
            n_cmp++;
            if (obs_src[i] !== exp_src[i] || obs_data[i] !== exp_data[i]) begin
               n_bad++; $display("FAIL rand%0d word %0d: got src %0d data %h want src %0d data %h", it, i, obs_src[i], obs_data[i], exp_src[i], exp_data[i]);
            end
         end
      end
   endtask

`ifdef MODULE_ARB_STATS_EN
   task automatic test_stats();
      bit to;
      apply_reset();
      rdy_pct = 80;
      push_words(3, 37);
      drive();
      run_idle(1000, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL stats timeout: got busy want idle"); end
      n_cmp++; if (word_count[3*32 +: 32] !== 32'd37) begin n_bad++; $display("FAIL stats count3: got %0d want 37", word_count[3*32 +: 32]); end
      n_cmp++; if (word_count[0 +: 96] !== '0) begin n_bad++; $display("FAIL stats others: got %h want 0", word_count[0 +: 96]); end
      stats_clr = 1'b1;
      push_words(3, 3);
      drive();
      run_idle(200, to);
      stats_clr = 1'b0;
      n_cmp++; if (word_count[3*32 +: 32] !== 32'd0) begin n_bad++; $display("FAIL stats clr: got %0d want 0", word_count[3*32 +: 32]); end
   endtask
`endif

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      cyc       = 0;
      multi_cnt = 0;
      bad_cnt   = 0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_enable_drop();
      test_async_reset();
      test_random();
`ifdef MODULE_ARB_STATS_EN
      test_stats();
`endif
      n_cmp++; if (multi_cnt != 0) begin n_bad++; $display("FAIL onehot in_ready: got %0d multi cycles want 0", multi_cnt); end
      n_cmp++; if (bad_cnt != 0)   begin n_bad++; $display("FAIL ineligible pop: got %0d want 0", bad_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
